// File: rtl/rf_hazard_ctrl.sv
// rf_hazard_ctrl: stall/flush control for the PC/IF-ID, RF and EX/MEM latches.
// Resolves memory wait, multiply occupancy, branch redirect and load-use hazards.
module rf_hazard_ctrl #(
    parameter int         MUL_CYCLES = 4,
    parameter logic [5:0] OP_LOAD    = 6'h20,
    parameter logic [5:0] OP_MUL     = 6'h1C
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  dec_rd0_id,
    input  logic        dec_rd0_used,
    input  logic [4:0]  dec_rd1_id,
    input  logic        dec_rd1_used,
    input  logic [5:0]  ex_opcode,
    input  logic [4:0]  ex_wr_id,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        br_taken,
    output logic        stall_if,
    output logic        flush_id,
    output logic        stall_rf,
    output logic        flush_rf,
    output logic        stall_mem,
    output logic        flush_mem,
    output logic        mul_busy,
    output logic [15:0] stall_cycles
);

    localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 2);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          br_pend_q, br_pend_d;
    logic [15:0]   scnt_q, scnt_d;

    logic mem_stall;
    logic ex_mul;
    logic mul_hold;
    logic load_use;
    logic redirect;
    logic stall_rf_raw;
    logic rd0_hit;
    logic rd1_hit;

    assign mem_stall = mem_req & ~mem_ack;
    assign ex_mul    = (ex_opcode == OP_MUL);
    assign mul_hold  = ((state_q == IDLE) & ex_mul)
                     | ((state_q == MUL_BUSY) & (cnt_q != '0));
    assign rd0_hit   = dec_rd0_used & (dec_rd0_id == ex_wr_id);
    assign rd1_hit   = dec_rd1_used & (dec_rd1_id == ex_wr_id);
    assign load_use  = (ex_opcode == OP_LOAD) & (ex_wr_id != 5'd0)
                     & (rd0_hit | rd1_hit);
    assign redirect  = br_taken | br_pend_q;

    assign stall_rf_raw = mem_stall | mul_hold;

    // Control outputs; all masked while reset is asserted.
    always_comb begin
        stall_if  = 1'b0;
        flush_id  = 1'b0;
        stall_rf  = 1'b0;
        flush_rf  = 1'b0;
        stall_mem = 1'b0;
        flush_mem = 1'b0;
        mul_busy  = 1'b0;
        if (!RST) begin
            stall_mem = mem_stall;
            stall_rf  = stall_rf_raw;
            flush_mem = mul_hold & ~mem_stall;
            flush_rf  = ~stall_rf_raw & (redirect | load_use);
            flush_id  = ~stall_rf_raw & redirect;
            stall_if  = stall_rf_raw | (load_use & ~redirect);
            mul_busy  = (state_q == MUL_BUSY);
        end
    end

    // Next-state: multiply FSM, deferred redirect flag, stall counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        br_pend_d = stall_rf_raw & (br_pend_q | br_taken);
        scnt_d    = scnt_q;
        if (stall_rf_raw && scnt_q != 16'hFFFF) begin
            scnt_d = scnt_q + 16'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (ex_mul) begin
                    state_d = MUL_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MUL_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!mem_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            br_pend_q <= 1'b0;
            scnt_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            br_pend_q <= br_pend_d;
            scnt_q    <= scnt_d;
        end
    end

    assign stall_cycles = scnt_q;

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// tb_rf_hazard_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the hazard rules.
module tb_rf_hazard_ctrl;

    localparam int MULC = 4;
    localparam logic [5:0] LD = 6'h20;
    localparam logic [5:0] ML = 6'h1C;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  dec_rd0_id, dec_rd1_id, ex_wr_id;
    logic        dec_rd0_used, dec_rd1_used;
    logic [5:0]  ex_opcode;
    logic        mem_req, mem_ack, br_taken;
    logic        stall_if, flush_id, stall_rf, flush_rf;
    logic        stall_mem, flush_mem, mul_busy;
    logic [15:0] stall_cycles;
    logic [6:0]  ctl;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit   m_busy;
    int   m_age;
    bit   m_pend;
    int   m_scnt;
    logic [6:0] e_ctl;
    bit   e_stall_rf;
    bit   e_mstall;

    rf_hazard_ctrl #(.MUL_CYCLES(MULC), .OP_LOAD(LD), .OP_MUL(ML)) dut (
        .CLK(CLK), .RST(RST),
        .dec_rd0_id(dec_rd0_id), .dec_rd0_used(dec_rd0_used),
        .dec_rd1_id(dec_rd1_id), .dec_rd1_used(dec_rd1_used),
        .ex_opcode(ex_opcode), .ex_wr_id(ex_wr_id),
        .mem_req(mem_req), .mem_ack(mem_ack), .br_taken(br_taken),
        .stall_if(stall_if), .flush_id(flush_id),
        .stall_rf(stall_rf), .flush_rf(flush_rf),
        .stall_mem(stall_mem), .flush_mem(flush_mem),
        .mul_busy(mul_busy), .stall_cycles(stall_cycles)
    );

    assign ctl = {stall_if, flush_id, stall_rf, flush_rf,
                  stall_mem, flush_mem, mul_busy};

    always #5 CLK = ~CLK;

    // Expected controls from the priority rules:
    // mem wait > multiply > redirect > load-use.
    function automatic void model_eval();
        bit ld_use, mhold, redir, si, fi, sr, fr, sm, fm;
        e_mstall = mem_req && !mem_ack;
        mhold = m_busy ? (m_age < MULC - 1) : (ex_opcode == ML);
        ld_use = (ex_opcode == LD) && (ex_wr_id != 0) &&
                 ((dec_rd0_used && dec_rd0_id == ex_wr_id) ||
                  (dec_rd1_used && dec_rd1_id == ex_wr_id));
        redir = br_taken || m_pend;
        si = 0; fi = 0; sr = 0; fr = 0; sm = 0; fm = 0;
        e_stall_rf = e_mstall || mhold;
        if (e_stall_rf) begin
            si = 1; sr = 1; sm = e_mstall;
            fm = mhold && !e_mstall;
        end else if (redir) begin
            fi = 1; fr = 1;
        end else if (ld_use) begin
            si = 1; fr = 1;
        end
        e_ctl = {si, fi, sr, fr, sm, fm, m_busy};
        if (RST) e_ctl = 7'd0;
    endfunction

    function automatic void model_update();
        if (RST) begin
            m_busy = 0; m_age = 0; m_pend = 0; m_scnt = 0;
            return;
        end
        m_pend = e_stall_rf ? (m_pend || br_taken) : 1'b0;
        if (e_stall_rf && m_scnt < 65535) m_scnt++;
        if (!m_busy) begin
            if (ex_opcode == ML) begin
                m_busy = 1; m_age = 1;
            end
        end else if (m_age < MULC - 1) begin
            m_age++;
        end else if (!e_mstall) begin
            m_busy = 0; m_age = 0;
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        dec_rd0_id = 0; dec_rd0_used = 0;
        dec_rd1_id = 0; dec_rd1_used = 0;
        ex_opcode = 0; ex_wr_id = 0;
        mem_req = 0; mem_ack = 0; br_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1;
        tick();
        RST = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1;
        mem_req = 1; mem_ack = 0; ex_opcode = ML;
        @(negedge CLK);
        checks++;
        if (ctl !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp %b", ctl, 7'd0);
        end
        tick();
        RST = 0;
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (stall_cycles !== 16'd0 || ctl !== 7'd0) begin
            errors++;
            $display("FAIL reset_release got cnt=%0d ctl=%b exp 0/0",
                     stall_cycles, ctl);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_opcode = LD; ex_wr_id = 5;
        dec_rd1_used = 1; dec_rd1_id = 5;
        @(negedge CLK);
        checks++;
        if (ctl !== 7'b1001000) begin
            errors++;
            $display("FAIL lu_hit got %b exp %b", ctl, 7'b1001000);
        end
        tick();
        ex_opcode = 0; ex_wr_id = 0;
        @(negedge CLK);
        checks++;
        if (ctl !== 7'd0) begin
            errors++;
            $display("FAIL lu_bubble got %b exp %b", ctl, 7'd0);
        end
        tick();
        ex_opcode = LD; ex_wr_id = 0;
        dec_rd1_id = 0; dec_rd0_used = 1; dec_rd0_id = 0;
        @(negedge CLK);
        checks++;
        if (ctl !== 7'd0) begin
            errors++;
            $display("FAIL lu_r0 got %b exp %b", ctl, 7'd0);
        end
        tick();
    endtask

    task automatic test_multiply();
        logic [6:0] exp_c [4];
        exp_c = '{7'b1010010, 7'b1010011, 7'b1010011, 7'b0000001};
        do_reset();
        ex_opcode = ML;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++;
            if (ctl !== exp_c[c]) begin
                errors++;
                $display("FAIL mul_c%0d got %b exp %b", c + 1, ctl, exp_c[c]);
            end
            tick();
        end
        ex_opcode = 0;
        @(negedge CLK);
        checks++;
        if (stall_cycles !== 16'd3 || ctl !== 7'd0) begin
            errors++;
            $display("FAIL mul_end got cnt=%0d ctl=%b exp 3/0",
                     stall_cycles, ctl);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ack = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            checks++;
            if (ctl !== 7'b1010100) begin
                errors++;
                $display("FAIL memw_c%0d got %b exp %b", c, ctl, 7'b1010100);
            end
            tick();
        end
        mem_ack = 1;
        @(negedge CLK);
        checks++;
        if (ctl !== 7'd0) begin
            errors++;
            $display("FAIL memw_ack got %b exp %b", ctl, 7'd0);
        end
        tick();
        mem_req = 0; mem_ack = 0;
        @(negedge CLK);
        checks++;
        if (stall_cycles !== 16'd5) begin
            errors++;
            $display("FAIL memw_cnt got %0d exp 5", stall_cycles);
        end
    endtask

    task automatic test_branch_stall();
        do_reset();
        mem_req = 1; mem_ack = 0;
        for (int c = 0; c < 3; c++) begin
            br_taken = (c == 0);
            @(negedge CLK);
            checks++;
            if (ctl !== 7'b1010100) begin
                errors++;
                $display("FAIL brs_c%0d got %b exp %b", c, ctl, 7'b1010100);
            end
            tick();
        end
        br_taken = 0; mem_ack = 1;
        @(negedge CLK);
        checks++;
        if (ctl !== 7'b0101000) begin
            errors++;
            $display("FAIL brs_apply got %b exp %b", ctl, 7'b0101000);
        end
        tick();
        mem_req = 0; mem_ack = 0;
        @(negedge CLK);
        checks++;
        if (ctl !== 7'd0) begin
            errors++;
            $display("FAIL brs_once got %b exp %b", ctl, 7'd0);
        end
        tick();
    endtask

    task automatic test_mul_mem();
        logic [6:0] exp_c [7];
        exp_c = '{7'b1010010, 7'b1010011, 7'b1010011, 7'b1010101,
                  7'b1010101, 7'b0000001, 7'b0000000};
        do_reset();
        ex_opcode = ML;
        for (int c = 0; c < 7; c++) begin
            mem_req = (c == 3 || c == 4 || c == 5);
            mem_ack = (c == 5);
            if (c == 6) ex_opcode = 0;
            @(negedge CLK);
            checks++;
            if (ctl !== exp_c[c]) begin
                errors++;
                $display("FAIL mulmem_c%0d got %b exp %b", c + 1, ctl, exp_c[c]);
            end
            tick();
        end
        checks++;
        if (stall_cycles !== 16'd5) begin
            errors++;
            $display("FAIL mulmem_cnt got %0d exp 5", stall_cycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1; mem_ack = 0;
        for (int c = 0; c < 65540; c++) tick();
        @(negedge CLK);
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got %h exp ffff", stall_cycles);
        end
        tick();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_nowrap got %h exp ffff", stall_cycles);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            RST = ($urandom_range(0, 63) == 0);
            case ($urandom_range(0, 3))
                0: ex_opcode = LD;
                1: ex_opcode = ML;
                2: ex_opcode = 6'($urandom);
                default: ex_opcode = 0;
            endcase
            ex_wr_id = 5'($urandom_range(0, 3));
            dec_rd0_id = 5'($urandom_range(0, 3));
            dec_rd1_id = 5'($urandom_range(0, 3));
            dec_rd0_used = 1'($urandom);
            dec_rd1_used = 1'($urandom);
            mem_req = 1'($urandom);
            mem_ack = 1'($urandom);
            br_taken = ($urandom_range(0, 3) == 0);
            @(negedge CLK);
            model_eval();
            checks++;
            if (ctl !== e_ctl || stall_cycles !== 16'(m_scnt)) begin
                errors++;
                $display("FAIL rand_%0d got ctl=%b cnt=%0d exp ctl=%b cnt=%0d",
                         n, ctl, stall_cycles, e_ctl, m_scnt);
            end
            tick();
        end
        RST = 0;
    endtask

    initial begin
        idle_inputs();
        RST = 1;
        test_reset();
        test_load_use();
        test_multiply();
        test_mem_wait();
        test_branch_stall();
        test_mul_mem();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_hazard_ctrl.md
Name: rf_hazard_ctrl

Overview:
Pipeline hazard controller that generates the stall/flush controls for the RF-stage latch and its neighbouring latches: PC/IF-ID, and EX/MEM.
It consumes three sources:
- the decode-side source register ids;
- the RF-latch outputs, i.e. the instruction currently in EX;
- the memory and branch status.
It detects load-use hazards, multi-cycle multiply occupancy of EX, memory wait states and taken-branch redirects, and resolves them with a fixed priority.

Parameters:
MUL_CYCLES, 4, total cycles a multiply occupies EX (must be >= 2)
OP_LOAD, 6'h20, opcode of load instructions
OP_MUL, 6'h1C, opcode of multiply instructions

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
dec_rd0_id  in  5  source 0 register id of instruction in RF stage
dec_rd0_used  in  1  source 0 is read
dec_rd1_id  in  5  source 1 register id of instruction in RF stage
dec_rd1_used  in  1  source 1 is read
ex_opcode  in  6  opcode held in RF latch (instruction in EX)
ex_wr_id  in  5  destination id held in RF latch
mem_req  in  1  MEM stage has an outstanding access
mem_ack  in  1  memory completes access this cycle
br_taken  in  1  EX resolved a taken branch this cycle
stall_if  out  1  hold PC and IF/ID latch
flush_id  out  1  zero IF/ID latch
stall_rf  out  1  hold RF latch
flush_rf  out  1  zero RF latch (bubble, opcode 0)
stall_mem  out  1  hold EX/MEM latch
flush_mem  out  1  bubble into EX/MEM latch
mul_busy  out  1  state == MUL_BUSY
stall_cycles  out  16  saturating count of cycles with stall_rf=1

Behaviour:
- State: FSM {IDLE, MUL_BUSY}, down-counter cnt, flag br_pending, counter stall_cycles.
- RST high: next state IDLE, cnt=0, br_pending=0, stall_cycles=0.
- RST high: all stall_*/flush_* outputs and mul_busy forced 0 combinationally during the reset cycle.
- Control outputs are combinational from current state and inputs, giving zero-cycle latency.
- Derived terms:
  - mem_stall = mem_req & ~mem_ack.
  - ex_mul = (ex_opcode == OP_MUL).
  - mul_hold = (IDLE & ex_mul) | (MUL_BUSY & cnt != 0).
  - load_use = (ex_opcode == OP_LOAD) & (ex_wr_id != 0) & ((dec_rd0_used & dec_rd0_id == ex_wr_id) | (dec_rd1_used & dec_rd1_id == ex_wr_id)).
  - redirect = br_taken | br_pending.
- Output equations:
  - stall_mem = mem_stall.
  - stall_rf = mem_stall | mul_hold.
  - flush_mem = mul_hold & ~mem_stall.
  - flush_rf = ~stall_rf & (redirect | load_use).
  - flush_id = ~stall_rf & redirect.
  - stall_if = stall_rf | (load_use & ~redirect).
- Priority: memory wait > multiply occupancy > branch redirect > load-use. Redirect cancels load-use, so there is no IF stall on a redirect.
- FSM transitions:
  - IDLE & ex_mul: go to MUL_BUSY, load cnt = MUL_CYCLES-2.
  - MUL_BUSY & cnt != 0: decrement cnt.
  - MUL_BUSY & cnt == 0 & ~mem_stall: go to IDLE.
  - MUL_BUSY & cnt == 0 & mem_stall: remain in MUL_BUSY. This prevents a held MUL from retriggering.
- cnt decrements even while mem_stall=1.
- A multiply therefore occupies EX for exactly MUL_CYCLES cycles when there is no mem wait, with MUL_CYCLES-1 of them having stall_rf=1.
- br_pending: set when br_taken & stall_rf; cleared on any cycle with stall_rf=0. A redirect arriving during a stall is therefore applied on the first unstalled cycle, and only once.
- stall_cycles: increments when stall_rf=1; saturates at 16'hFFFF with no wrap.
- Load-use inserts exactly one bubble, because the next cycle EX holds opcode 0.
- ex_wr_id == 0 never causes a load-use stall.

Test Plan:
- Reset: RST=1 with mem_req=1, mem_ack=0 and ex_opcode=OP_MUL -> all stall/flush outputs 0. After release, stall_cycles=0 and mul_busy=0.
- Load-use: ex_opcode=6'h20, ex_wr_id=5, dec_rd1_used=1, dec_rd1_id=5 -> stall_if=1, flush_rf=1, stall_rf=0 for 1 cycle. Repeating with ex_wr_id=0 -> no stall.
- Multiply with MUL_CYCLES=4: ex_opcode=6'h1C held -> stall_rf=1 and flush_mem=1 for 3 cycles, then 0 in cycle 4. mul_busy=1 in cycles 2-4. stall_cycles ends at 3.
- Memory wait: mem_req=1, mem_ack=0 for 5 cycles, then ack -> stall_if/stall_rf/stall_mem=1 for 5 cycles, flush_mem=0. stall_cycles=5.
- Branch during stall: br_taken pulsed 1 cycle while mem_stall=1 -> no flush then. On the first cycle after ack, flush_id=1 and flush_rf=1 exactly once.
- Combined multiply + mem wait: mem_stall asserted in the multiply's final cycle (cnt=0) -> FSM stays in MUL_BUSY with no retrigger. stall_rf drops the cycle mem_ack=1.
- Saturation: force more than 65535 stall cycles -> stall_cycles holds at 16'hFFFF.
